// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default widths
// and the read data returned when the memory watchdog abandons an access.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_ACC  = 2'd1,
        ST_CPU_RESP = 2'd2,
        ST_DBG_ACC  = 2'd3
    } arb_state_t;

    localparam int ARB_ADDR_W       = 64;
    localparam int ARB_DATA_W       = 64;
    localparam int ARB_STARVE_LIMIT = 4;

    localparam logic [63:0] ARB_TIMEOUT_FILL = 64'hDEAD_DEAD_DEAD_DEAD;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of CPU wins while the debug port waits; clear has priority
// over increment, and o_at_limit forces the next arbitration to the debug port.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = ARB_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (priority)
// and a debug/loader port. Optional mem_ack watchdog: DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W,
    parameter int STARVE_LIMIT   = ARB_STARVE_LIMIT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              arb_timeout_err
);

    arb_state_t        r_state, w_state_nxt;
    logic              w_cpu_req, w_dbg_win, w_at_limit;
    logic              w_cpu_grant, w_dbg_grant;
    logic              w_done, w_timeout;
    logic [DATA_W-1:0] w_rdata;

    logic              r_mem_req, r_mem_we, r_dbg_rvalid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_cpu_rdata, r_dbg_rdata;

    assign w_cpu_req = cpu_mem_read | cpu_mem_write;
    assign w_dbg_win = dbg_req & (~w_cpu_req | w_at_limit);
    assign w_done    = mem_ack | w_timeout;

    dmem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clock      (clock),
        .reset      (reset),
        .i_clr      (~dbg_req | w_dbg_grant),
        .i_inc      (w_cpu_grant & dbg_req),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cpu_grant = 1'b0;
        w_dbg_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dbg_win) begin
                    w_state_nxt = ST_DBG_ACC;
                    w_dbg_grant = 1'b1;
                end else if (w_cpu_req) begin
                    w_state_nxt = ST_CPU_ACC;
                    w_cpu_grant = 1'b1;
                end
            end
            ST_CPU_ACC:  if (w_done) w_state_nxt = ST_CPU_RESP;
            // The instruction's request is still high here; it must not re-issue.
            ST_CPU_RESP: w_state_nxt = ST_IDLE;
            ST_DBG_ACC:  if (w_done) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_dbg_rvalid <= 1'b0;
            if (w_dbg_grant) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= dbg_we;
                r_mem_addr  <= dbg_addr;
                r_mem_wdata <= dbg_wdata;
            end else if (w_cpu_grant) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= cpu_mem_write;
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
            end
            if ((r_state == ST_CPU_ACC) && w_done) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) r_cpu_rdata <= w_rdata;
            end
            if ((r_state == ST_DBG_ACC) && w_done) begin
                r_mem_req    <= 1'b0;
                r_dbg_rdata  <= w_rdata;
                r_dbg_rvalid <= 1'b1;
            end
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout_err;

    // r_wd_cnt is the number of un-acked request cycles already elapsed.
    assign w_timeout = r_mem_req & ~mem_ack & (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (r_mem_req && !mem_ack && !w_timeout) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end else begin
            r_wd_cnt <= '0;
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign w_rdata         = w_timeout ? DATA_W'(ARB_TIMEOUT_FILL) : mem_rdata;
    assign arb_timeout_err = r_timeout_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo    = (TIMEOUT_CYCLES != 0);
    assign w_timeout       = 1'b0;
    assign w_rdata         = mem_rdata;
    assign arb_timeout_err = 1'b0;
`endif

    assign cpu_stall  = w_cpu_req & (r_state != ST_CPU_RESP);
    assign dbg_gnt    = w_dbg_grant & ~reset;
    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;
    assign cpu_rdata  = r_cpu_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: CPU loads/stores, debug access, starvation
// hand-off, reset mid-access, and the watchdog when DMEM_ARB_TIMEOUT_EN is set.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_mem_read, cpu_mem_write;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        arb_timeout_err;

    int          n_checks = 0;
    int          n_errors = 0;

    // Memory responder: acks after n_waits wait states while ack_en is set.
    int          n_waits = 0;
    int          wait_cnt = 0;
    logic        ack_en = 1'b1;
    logic [63:0] rd_val = 64'h0;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .arb_timeout_err(arb_timeout_err)
    );

    assign mem_rdata = rd_val;

    always begin
        @(posedge clock);
        #1;
        if (mem_req && ack_en) begin
            mem_ack  = (wait_cnt == n_waits);
            wait_cnt = (wait_cnt == n_waits) ? 0 : wait_cnt + 1;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Drives one CPU access and walks it to CPU_RESP, checking stall length and
    // that the memory outputs hold the latched fields in every request cycle.
    task automatic cpu_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                              input int waits, input int exp_stall, input string tag);
        int stall_n;
        int req_n;
        stall_n       = 0;
        req_n         = 0;
        n_waits       = waits;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        cpu_mem_write = we;
        cpu_mem_read  = ~we;
        #1;
        while (cpu_stall && stall_n < 40) begin
            stall_n++;
            if (mem_req) begin
                req_n++;
                check_eq({tag, " mem_addr"}, mem_addr, addr);
                check_eq({tag, " mem_we"}, {63'h0, mem_we}, {63'h0, we});
                if (we) check_eq({tag, " mem_wdata"}, mem_wdata, wdata);
            end
            tick();
            #1;
        end
        check_eq({tag, " stall cycles"}, 64'(stall_n), 64'(exp_stall));
        check_eq({tag, " req cycles"}, 64'(req_n), 64'(waits + 1));
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
    endtask

    initial begin
        int cpu_before, cpu_after, gnts, rvalids, stall_low, dbg_we_cyc, k;
        logic prev_req;
        bit gnt_seen, drop_next, done;

        reset = 1'b1;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        mem_ack = 1'b0;
        tick();
        tick();

        check_eq("rst mem_req", {63'h0, mem_req}, 64'h0);
        check_eq("rst mem_we", {63'h0, mem_we}, 64'h0);
        check_eq("rst dbg_gnt", {63'h0, dbg_gnt}, 64'h0);
        check_eq("rst dbg_rvalid", {63'h0, dbg_rvalid}, 64'h0);
        check_eq("rst timeout_err", {63'h0, arb_timeout_err}, 64'h0);
        check_eq("rst cpu_rdata", cpu_rdata, 64'h0);
        check_eq("rst dbg_rdata", dbg_rdata, 64'h0);
        check_eq("rst mem_addr", mem_addr, 64'h0);
        check_eq("rst mem_wdata", mem_wdata, 64'h0);
        check_eq("rst cpu_stall", {63'h0, cpu_stall}, 64'h0);
        reset = 1'b0;
        tick();

        // CPU load, zero wait states
        rd_val = 64'h1234;
        cpu_access(1'b0, 64'h40, 64'h0, 0, 2, "load");
        check_eq("load cpu_rdata", cpu_rdata, 64'h1234);
        tick();

        // CPU store, three wait states; cpu_rdata must not change
        rd_val = 64'h9999;
        cpu_access(1'b1, 64'h80, 64'hAA, 3, 5, "store");
        check_eq("store keeps cpu_rdata", cpu_rdata, 64'h1234);
        tick();

        // Debug read with the CPU idle
        n_waits = 0;
        rd_val = 64'h5555;
        dbg_req = 1'b1; dbg_addr = 64'h10; dbg_we = 1'b0;
        #1;
        check_eq("dbg gnt at T", {63'h0, dbg_gnt}, 64'h1);
        check_eq("dbg no stall", {63'h0, cpu_stall}, 64'h0);
        tick();
        dbg_req = 1'b0;
        #1;
        check_eq("dbg T+1 mem_req", {63'h0, mem_req}, 64'h1);
        check_eq("dbg T+1 mem_addr", mem_addr, 64'h10);
        check_eq("dbg T+1 mem_we", {63'h0, mem_we}, 64'h0);
        check_eq("dbg T+1 gnt low", {63'h0, dbg_gnt}, 64'h0);
        check_eq("dbg T+1 rvalid low", {63'h0, dbg_rvalid}, 64'h0);
        tick();
        #1;
        check_eq("dbg T+2 rvalid", {63'h0, dbg_rvalid}, 64'h1);
        check_eq("dbg T+2 rdata", dbg_rdata, 64'h5555);
        check_eq("dbg T+2 mem_req", {63'h0, mem_req}, 64'h0);
        tick();
        #1;
        check_eq("dbg T+3 rvalid low", {63'h0, dbg_rvalid}, 64'h0);
        tick();

        // Starvation: CPU loads back to back while a debug write waits
        rd_val = 64'h4242;
        n_waits = 0;
        cpu_addr = 64'h40; cpu_mem_read = 1'b1;
        dbg_addr = 64'h20; dbg_we = 1'b1; dbg_wdata = 64'h77; dbg_req = 1'b1;
        cpu_before = 0; cpu_after = 0; gnts = 0; rvalids = 0; stall_low = 0; dbg_we_cyc = 0;
        prev_req = 1'b0; gnt_seen = 1'b0; drop_next = 1'b0; done = 1'b0;
        #1;
        for (int c = 0; c < 80 && !done; c++) begin
            if (drop_next) begin
                dbg_req = 1'b0;
                drop_next = 1'b0;
            end
            if (dbg_gnt) begin
                gnts++;
                gnt_seen = 1'b1;
                drop_next = 1'b1;
            end
            if (mem_req && !prev_req && mem_addr == 64'h40) begin
                if (!gnt_seen) cpu_before++;
                else           cpu_after++;
            end
            if (mem_req && mem_addr == 64'h20) begin
                if (!cpu_stall) stall_low++;
                if (mem_we)     dbg_we_cyc++;
            end
            if (dbg_rvalid) rvalids++;
            if (cpu_after > 0) done = 1'b1;
            prev_req = mem_req;
            tick();
            #1;
        end
        check_eq("starve cpu grants before dbg", 64'(cpu_before), 64'd4);
        check_eq("starve dbg grants", 64'(gnts), 64'd1);
        check_eq("starve dbg rvalid", 64'(rvalids), 64'd1);
        check_eq("starve stall low during dbg", 64'(stall_low), 64'd0);
        check_eq("starve dbg write strobe", 64'(dbg_we_cyc), 64'd1);
        check_eq("starve cpu resumed", 64'(cpu_after), 64'd1);
        k = 0;
        while (cpu_stall && k < 20) begin
            k++;
            tick();
            #1;
        end
        check_eq("starve resumed load data", cpu_rdata, 64'h4242);
        cpu_mem_read = 1'b0;
        dbg_we = 1'b0;
        tick();

        // Reset while the CPU access is waiting on a withheld ack
        ack_en = 1'b0;
        cpu_addr = 64'h100; cpu_mem_read = 1'b1;
        tick();
        #1;
        check_eq("midrst in CPU_ACC", {63'h0, mem_req}, 64'h1);
        reset = 1'b1;
        cpu_mem_read = 1'b0;
        tick();
        #1;
        check_eq("midrst mem_req", {63'h0, mem_req}, 64'h0);
        check_eq("midrst cpu_rdata", cpu_rdata, 64'h0);
        check_eq("midrst dbg_rvalid", {63'h0, dbg_rvalid}, 64'h0);
        check_eq("midrst cpu_stall", {63'h0, cpu_stall}, 64'h0);
        reset = 1'b0;
        ack_en = 1'b1;
        tick();
        #1;
        check_eq("midrst no reissue", {63'h0, mem_req}, 64'h0);
        check_eq("midrst no rvalid", {63'h0, dbg_rvalid}, 64'h0);
        check_eq("timeout_err clear", {63'h0, arb_timeout_err}, 64'h0);
        tick();

        // After the abandoned access the arbiter is idle and grants at once
        rd_val = 64'h3030;
        dbg_req = 1'b1; dbg_addr = 64'h30;
        #1;
        check_eq("post-rst dbg gnt", {63'h0, dbg_gnt}, 64'h1);
        tick();
        dbg_req = 1'b0;
        tick();
        #1;
        check_eq("post-rst dbg rdata", dbg_rdata, 64'h3030);
        tick();

`ifdef DMEM_ARB_TIMEOUT_EN
        // Watchdog: 16 un-acked request cycles complete the access with fill data
        ack_en = 1'b0;
        rd_val = 64'h1111;
        cpu_access(1'b0, 64'h200, 64'h0, 15, 17, "timeout");
        check_eq("timeout fill", cpu_rdata, 64'hDEAD_DEAD_DEAD_DEAD);
        check_eq("timeout err set", {63'h0, arb_timeout_err}, 64'h1);
        tick();
        tick();
        #1;
        check_eq("timeout err sticky", {63'h0, arb_timeout_err}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ack_en = 1'b1;
        #1;
        check_eq("timeout err reset", {63'h0, arb_timeout_err}, 64'h0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
